fusion_unit_seq: RTL

//  Sequential, parametrised two-sensor covariance-weighted fusion engine, one diagonal element per transaction.
//  Per element i: Xf = (P2*X1 + P1*X2)/(P1+P2), Pf = P1*P2/(P1+P2).
//  One shared restoring divider replaces per-element combinational reciprocals.

---
 rtl/fusion_pkg.sv | 32 +++
 rtl/fusion_unit_seq_if.sv | 34 +++
 rtl/fusion_unit_seq_div.sv | 66 ++++++
 rtl/fusion_unit_seq.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fusion_pkg.sv
// Shared types and timing helpers for the sequential two-sensor fusion engine.
// Optional build macro: FUSION_ROUND_EN (see fusion_unit_seq.sv).
package fusion_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV_X = 2'd1,
        DIV_P = 2'd2,
        HOLD  = 2'd3
    } fusion_state_t;

    // Divider iteration counts: the state quotient carries a sign/guard pair,
    // the variance quotient does not.
    function automatic int div_x_cycles(input int w);
        return 2 * w + 2;
    endfunction

    function automatic int div_p_cycles(input int w);
        return 2 * w;
    endfunction

    // Accept edge to out_valid: both divisions plus the launch cycle.
    function automatic int fusion_latency(input int w);
        return div_x_cycles(w) + div_p_cycles(w) + 1;
    endfunction

    localparam int FUSION_DEF_W    = 16;
    localparam int DIV_X_CYCLES    = div_x_cycles(FUSION_DEF_W);
    localparam int DIV_P_CYCLES    = div_p_cycles(FUSION_DEF_W);
    localparam int FUSION_LATENCY  = fusion_latency(FUSION_DEF_W);

endpackage

// File: rtl/fusion_unit_seq_if.sv
// Element-in / result-out handshake bundle of the fusion engine.
// master = producer/consumer side, slave = the engine.
interface fusion_unit_seq_if #(
    parameter int W        = 16,
    parameter int N_STATES = 6
);
    localparam int IW = (N_STATES > 1) ? $clog2(N_STATES) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic        [W-1:0]  in_p1;
    logic        [W-1:0]  in_p2;
    logic signed [W-1:0]  in_x1;
    logic signed [W-1:0]  in_x2;

    logic                 out_valid;
    logic                 out_ready;
    logic signed [W-1:0]  out_xf;
    logic        [W-1:0]  out_pf;
    logic        [IW-1:0] out_idx;
    logic                 out_last;
    logic                 out_div0;

    modport master (
        output in_valid, in_p1, in_p2, in_x1, in_x2, out_ready,
        input  in_ready, out_valid, out_xf, out_pf, out_idx, out_last, out_div0
    );

    modport slave (
        input  in_valid, in_p1, in_p2, in_x1, in_x2, out_ready,
        output in_ready, out_valid, out_xf, out_pf, out_idx, out_last, out_div0
    );

endinterface

// File: rtl/fusion_unit_seq_div.sv
// seq_div: unsigned restoring divider, one quotient bit per clock.
// The start cycle already performs the first iteration, so a run of `len`
// iterations ends `len` edges after start; done pulses the cycle after.
// Only the top `len` bits of the dividend are consumed (caller left-aligns).
module seq_div #(
    parameter int DIVIDEND_W = 34,
    parameter int DIVISOR_W  = 17,
    parameter int QUOTIENT_W = DIVIDEND_W,
    localparam int CW        = $clog2(DIVIDEND_W + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CW-1:0]         len,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [QUOTIENT_W-1:0] quotient
);

    logic [DIVISOR_W-1:0]  rem_q,  src_rem, rem_d;
    logic [DIVIDEND_W-1:0] dvd_q,  src_dvd;
    logic [QUOTIENT_W-1:0] quo_q,  src_quo;
    logic [CW-1:0]         cnt_q;
    logic                  done_q;
    logic [DIVISOR_W:0]    trial, diff;
    logic                  ge, step;

    assign busy     = (cnt_q != '0);
    assign done     = done_q;
    assign quotient = quo_q;
    assign step     = start | busy;

    // One restoring step; a start restarts from a clean remainder.
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_dvd = start ? dividend : dvd_q;
        src_quo = start ? '0 : quo_q;
        trial   = {src_rem, src_dvd[DIVIDEND_W-1]};
        diff    = trial - {1'b0, divisor};
        ge      = ~diff[DIVISOR_W];   // no borrow: trial >= divisor
        rem_d   = ge ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
    end

    // Iteration registers and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            dvd_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (step) begin
                rem_q  <= rem_d;
                dvd_q  <= src_dvd << 1;
                quo_q  <= (src_quo << 1) | QUOTIENT_W'(ge);
                cnt_q  <= (start ? len : cnt_q) - CW'(1);
                done_q <= start ? (len == CW'(1)) : (cnt_q == CW'(1));
            end
        end
    end

endmodule

// File: rtl/fusion_unit_seq.sv
// fusion_unit_seq: covariance-weighted fusion of two sensor estimates,
// one diagonal element per transaction, sharing one sequential divider.
//   Xf = (P2*X1 + P1*X2) / (P1+P2),  Pf = P1*P2 / (P1+P2)
// Build macro FUSION_ROUND_EN: round half away from zero instead of truncating.
module fusion_unit_seq
    import fusion_pkg::*;
#(
    parameter int W        = 16,
    parameter int FRAC     = 15,
    parameter int N_STATES = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    fusion_unit_seq_if.slave  bus
);

    localparam int IW  = (N_STATES > 1) ? $clog2(N_STATES) : 1;
    localparam int DW  = 2 * W + 2;
    localparam int DCW = $clog2(DW + 1);

    // FRAC only documents the binary point; the arithmetic is scale-free.
    if (FRAC >= W) begin : g_frac_chk
        $error("fusion_unit_seq: FRAC must be below W");
    end

    fusion_state_t       state_q, state_d;
    logic        [W-1:0] p1_q, p2_q;
    logic signed [W-1:0] x1_q, x2_q;
    logic        [W:0]   s_q;
    logic signed [W-1:0] xf_q;
    logic        [W-1:0] pf_q;
    logic                div0_q;
    logic       [IW-1:0] idx_q;

    logic signed [DW-1:0] nx;
    logic        [DW-1:0] mag, x_dvd;
    logic      [2*W-1:0]  np, p_sum;
    logic                 s_zero;

    logic                 div_start, div_busy, div_done;
    logic       [DCW-1:0] div_len;
    logic        [DW-1:0] div_dvd;
    logic         [W-1:0] div_quo;

    // Numerators from the latched operands; all terms widened to DW first.
    assign nx = $signed({{(W+2){1'b0}}, p2_q}) * $signed({{(W+2){x1_q[W-1]}}, x1_q})
              + $signed({{(W+2){1'b0}}, p1_q}) * $signed({{(W+2){x2_q[W-1]}}, x2_q});
    assign mag    = nx[DW-1] ? DW'(-nx) : DW'(nx);
    assign np     = {{W{1'b0}}, p1_q} * {{W{1'b0}}, p2_q};
    assign s_zero = (s_q == '0);

`ifdef FUSION_ROUND_EN
    // Bias the magnitude by floor(S/2) so the truncating divider rounds.
    assign x_dvd = mag + {{(W+2){1'b0}}, s_q[W:1]};
    assign p_sum = np  + {{W{1'b0}}, s_q[W:1]};
`else
    assign x_dvd = mag;
    assign p_sum = np;
`endif

    seq_div #(
        .DIVIDEND_W (DW),
        .DIVISOR_W  (W + 1),
        .QUOTIENT_W (W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .len      (div_len),
        .dividend (div_dvd),
        .divisor  (s_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_xf    = xf_q;
    assign bus.out_pf    = pf_q;
    assign bus.out_div0  = div0_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = (idx_q == IW'(N_STATES - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and divider launch. The P division is launched in the same
    // cycle the X quotient is ready so no cycle is lost between them. With
    // S == 0 each phase passes through for one cycle without dividing.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        div_dvd   = x_dvd;
        div_len   = DCW'(div_x_cycles(W));
        unique case (state_q)
            IDLE:  if (bus.in_valid) state_d = DIV_X;
            DIV_X: begin
                if (s_zero) begin
                    state_d = DIV_P;
                end else if (div_done) begin
                    state_d   = DIV_P;
                    div_start = 1'b1;
                    div_dvd   = {p_sum, 2'b00};
                    div_len   = DCW'(div_p_cycles(W));
                end else if (!div_busy) begin
                    div_start = 1'b1;
                end
            end
            DIV_P: if (s_zero || div_done) state_d = HOLD;
            HOLD:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, result capture and frame index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_q   <= '0;
            p2_q   <= '0;
            x1_q   <= '0;
            x2_q   <= '0;
            s_q    <= '0;
            xf_q   <= '0;
            pf_q   <= '0;
            div0_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.in_valid) begin
                    p1_q <= bus.in_p1;
                    p2_q <= bus.in_p2;
                    x1_q <= bus.in_x1;
                    x2_q <= bus.in_x2;
                    s_q  <= {1'b0, bus.in_p1} + {1'b0, bus.in_p2};
                end
                DIV_X: begin
                    if (s_zero)        xf_q <= '0;
                    else if (div_done) xf_q <= nx[DW-1] ? $signed(-div_quo) : $signed(div_quo);
                end
                DIV_P: begin
                    if (s_zero) begin
                        pf_q   <= '0;
                        div0_q <= 1'b1;
                    end else if (div_done) begin
                        pf_q   <= div_quo;
                        div0_q <= 1'b0;
                    end
                end
                HOLD: if (bus.out_ready)
                    idx_q <= (idx_q == IW'(N_STATES - 1)) ? '0 : idx_q + IW'(1);
                default: ;
            endcase
        end
    end

endmodule
